// File: rtl/dunit_step_ctrl.sv
// dunit_step_ctrl: debug-unit execution sequencer gating the MIPS pipeline clock-enable
//
// Ports:
//   i_clk, i_reset      clock and synchronous active-high reset
//   i_cmd_valid, i_cmd  command strobe and code (00 NOP, 01 RUN, 10 STEP, 11 STOP)
//   i_step_count        cycle count for STEP, sampled with the command
//   i_halt_wb           HALT retiring in WB (only meaningful while the pipeline advances)
//   o_dunit_clk_en      pipeline advance enable
//   o_busy              running or stepping
//   o_halted            program has retired HALT
//   o_done              one-cycle pulse on STEP end, STOP, or HALT
//   o_cmd_err           one-cycle pulse when a command is dropped
//   o_cycle_count       saturating count of enabled cycles since reset
module dunit_step_ctrl #(
    parameter int NB_STEP = 16,
    parameter int NB_CYC  = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    input  logic [1:0]         i_cmd,
    input  logic [NB_STEP-1:0] i_step_count,
    input  logic               i_halt_wb,
    output logic               o_dunit_clk_en,
    output logic               o_busy,
    output logic               o_halted,
    output logic               o_done,
    output logic               o_cmd_err,
    output logic [NB_CYC-1:0]  o_cycle_count
);
    typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;
    state_t state, next_state;
    logic [NB_STEP-1:0] step_rem, next_rem;
    logic next_done, next_err;
    logic cmd_run, cmd_step, cmd_stop, halt;
    assign cmd_run  = i_cmd_valid && i_cmd == 2'b01;
    assign cmd_step = i_cmd_valid && i_cmd == 2'b10;
    assign cmd_stop = i_cmd_valid && i_cmd == 2'b11;
    // WB stays frozen holding HALT while disabled, so only trust it on advancing cycles
    assign halt = i_halt_wb && o_dunit_clk_en;
    always_comb begin
        next_state = state;
        next_rem   = step_rem;
        next_done  = 1'b0;
        next_err   = 1'b0;
        case (state)
            IDLE: begin
                next_state = cmd_run ? RUN : (cmd_step && i_step_count != '0) ? STEP : IDLE;
                next_rem   = cmd_step ? i_step_count : step_rem;
                next_done  = cmd_step && i_step_count == '0;
            end
            RUN: begin
                next_state = halt ? HALTED : cmd_stop ? IDLE : RUN;
                next_done  = halt || cmd_stop;
                next_err   = cmd_run || cmd_step;
            end
            STEP: begin
                // halt beats stop beats exhaustion; all of them yield a single done pulse
                next_state = halt ? HALTED : (cmd_stop || step_rem == NB_STEP'(1)) ? IDLE : STEP;
                next_rem   = (halt || cmd_stop) ? '0 : step_rem - NB_STEP'(1);
                next_done  = halt || cmd_stop || step_rem == NB_STEP'(1);
                next_err   = cmd_run || cmd_step;
            end
            HALTED: next_err = cmd_run || cmd_step;
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= IDLE;
            step_rem       <= '0;
            o_dunit_clk_en <= 1'b0;
            o_busy         <= 1'b0;
            o_halted       <= 1'b0;
            o_done         <= 1'b0;
            o_cmd_err      <= 1'b0;
            o_cycle_count  <= '0;
        end else begin
            state          <= next_state;
            step_rem       <= next_rem;
            o_dunit_clk_en <= next_state == RUN || next_state == STEP;
            o_busy         <= next_state == RUN || next_state == STEP;
            o_halted       <= next_state == HALTED;
            o_done         <= next_done;
            o_cmd_err      <= next_err;
            o_cycle_count  <= (o_dunit_clk_en && !(&o_cycle_count)) ? o_cycle_count + NB_CYC'(1) : o_cycle_count;
        end
    end
endmodule

// File: tb/tb_dunit_step_ctrl.sv
// tb_dunit_step_ctrl: directed vector bench for dunit_step_ctrl
module tb_dunit_step_ctrl;
    localparam logic [1:0] NOP = 2'b00, RUN = 2'b01, STEP = 2'b10, STOP = 2'b11;
    logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, halt_wb = 1'b0;
    logic [1:0]  cmd = NOP;
    logic [15:0] step_count = '0;
    logic        en, busy, halted, done, err;
    logic [31:0] cnt;
    logic        en4, busy4, halted4, done4, err4;
    logic [3:0]  cnt4;
    int checks = 0, failures = 0;
    typedef struct {
        logic v; logic [1:0] cmd; logic [15:0] n; logic h;
        logic en, halted, done, err; logic [31:0] cnt;
    } vec_t;
    vec_t vecs[$];
    dunit_step_ctrl dut (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .i_step_count(step_count), .i_halt_wb(halt_wb), .o_dunit_clk_en(en),
        .o_busy(busy), .o_halted(halted), .o_done(done), .o_cmd_err(err), .o_cycle_count(cnt)
    );
    dunit_step_ctrl #(.NB_STEP(4), .NB_CYC(4)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .i_step_count(step_count[3:0]), .i_halt_wb(halt_wb), .o_dunit_clk_en(en4),
        .o_busy(busy4), .o_halted(halted4), .o_done(done4), .o_cmd_err(err4), .o_cycle_count(cnt4)
    );
    always #5 clk = ~clk;
    function automatic vec_t mk(input logic v, input logic [1:0] c, input logic [15:0] n, input logic h,
                                input logic e, input logic hl, input logic d, input logic er, input int ct);
        vec_t r;
        r.v = v; r.cmd = c; r.n = n; r.h = h;
        r.en = e; r.halted = hl; r.done = d; r.err = er; r.cnt = ct;
        return r;
    endfunction
    task automatic drive(input logic v, input logic [1:0] c, input logic [15:0] n, input logic h);
        cmd_valid = v; cmd = c; step_count = n; halt_wb = h;
    endtask
    task automatic chk(input string name, input logic e, input logic hl, input logic d, input logic er, input int ct);
        checks++;
        if ({en, busy, halted, done, err, cnt} !== {e, e, hl, d, er, ct[31:0]}) begin
            failures++;
            $display("FAIL %s: got en=%0b busy=%0b halted=%0b done=%0b err=%0b cnt=%0d expected en=%0b busy=%0b halted=%0b done=%0b err=%0b cnt=%0d",
                     name, en, busy, halted, done, err, cnt, e, e, hl, d, er, ct);
        end
    endtask
    task automatic chk_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic do_reset();
        rst = 1'b1;
        drive(0, NOP, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        // STEP 3
        vecs.push_back(mk(1, STEP, 3, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, NOP,  0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, NOP,  0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, NOP,  0, 0, 1, 0, 0, 0, 2));
        vecs.push_back(mk(0, NOP,  0, 0, 0, 0, 1, 0, 3));
        vecs.push_back(mk(0, NOP,  0, 0, 0, 0, 0, 0, 3));
        // STEP 0: done only
        vecs.push_back(mk(1, STEP, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk(0, NOP,  0, 0, 0, 0, 1, 0, 3));
        vecs.push_back(mk(0, NOP,  0, 0, 0, 0, 0, 0, 3));
        // RUN, STOP on the 10th enabled cycle
        vecs.push_back(mk(1, RUN,  0, 0, 0, 0, 0, 0, 3));
        for (int k = 0; k < 9; k++) vecs.push_back(mk(0, NOP, 0, 0, 1, 0, 0, 0, 3 + k));
        vecs.push_back(mk(1, STOP, 0, 0, 1, 0, 0, 0, 12));
        vecs.push_back(mk(0, NOP,  0, 0, 0, 0, 1, 0, 13));
        // STEP 2 after stop
        vecs.push_back(mk(1, STEP, 2, 0, 0, 0, 0, 0, 13));
        vecs.push_back(mk(0, NOP,  0, 0, 1, 0, 0, 0, 13));
        vecs.push_back(mk(0, NOP,  0, 0, 1, 0, 0, 0, 14));
        vecs.push_back(mk(0, NOP,  0, 0, 0, 0, 1, 0, 15));
        // STEP 4 with a RUN dropped mid-step
        vecs.push_back(mk(1, STEP, 4, 0, 0, 0, 0, 0, 15));
        vecs.push_back(mk(0, NOP,  0, 0, 1, 0, 0, 0, 15));
        vecs.push_back(mk(1, RUN,  0, 0, 1, 0, 0, 0, 16));
        vecs.push_back(mk(0, NOP,  0, 0, 1, 0, 0, 1, 17));
        vecs.push_back(mk(0, NOP,  0, 0, 1, 0, 0, 0, 18));
        vecs.push_back(mk(0, NOP,  0, 0, 0, 0, 1, 0, 19));
        // STOP while idle is silent; halt ignored while disabled
        vecs.push_back(mk(1, STOP, 0, 1, 0, 0, 0, 0, 19));
        vecs.push_back(mk(0, NOP,  0, 0, 0, 0, 0, 0, 19));
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        foreach (vecs[i]) begin
            chk($sformatf("vec%0d", i), vecs[i].en, vecs[i].halted, vecs[i].done, vecs[i].err, vecs[i].cnt);
            drive(vecs[i].v, vecs[i].cmd, vecs[i].n, vecs[i].h);
            @(negedge clk);
        end
        // HALT on 7th enabled cycle of RUN
        do_reset();
        drive(1, RUN, 0, 0);
        @(negedge clk);
        drive(0, NOP, 0, 0);
        repeat (6) @(negedge clk);
        chk("halt_pre", 1, 0, 0, 0, 6);
        drive(0, NOP, 0, 1);
        @(negedge clk);
        chk("halt_hit", 0, 1, 1, 0, 7);
        @(negedge clk);
        chk("halt_hold", 0, 1, 0, 0, 7);
        drive(1, RUN, 0, 0);
        @(negedge clk);
        chk("halted_run_err", 0, 1, 0, 1, 7);
        drive(1, STOP, 0, 1);
        @(negedge clk);
        chk("halted_stop", 0, 1, 0, 0, 7);
        drive(0, NOP, 0, 0);
        @(negedge clk);
        chk("halted_quiet", 0, 1, 0, 0, 7);
        // HALT and STOP coincident on 2nd cycle of STEP 5
        do_reset();
        drive(1, STEP, 5, 0);
        @(negedge clk);
        drive(0, NOP, 0, 0);
        @(negedge clk);
        chk("coinc_pre", 1, 0, 0, 0, 1);
        drive(1, STOP, 0, 1);
        @(negedge clk);
        chk("coinc_hit", 0, 1, 1, 0, 2);
        drive(0, NOP, 0, 0);
        @(negedge clk);
        chk("coinc_after", 0, 1, 0, 0, 2);
        // reset mid-RUN
        do_reset();
        drive(1, RUN, 0, 0);
        @(negedge clk);
        drive(0, NOP, 0, 0);
        repeat (3) @(negedge clk);
        chk("run_pre_reset", 1, 0, 0, 0, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("run_reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        // saturation on the narrow instance; also max step count there
        begin
            int en_cycles = 0;
            bit seen = 0;
            drive(1, STEP, 15, 0);
            @(negedge clk);
            drive(0, NOP, 0, 0);
            for (int k = 0; k < 40 && !seen; k++) begin
                if (en4) en_cycles++;
                if (done4) seen = 1;
                @(negedge clk);
            end
            chk_val("sat_done_seen", int'(seen), 1);
            chk_val("sat_step_cycles", en_cycles, 15);
            chk_val("sat_cnt4_15", int'(cnt4), 15);
            chk_val("sat_cnt_wide", int'(cnt), 15);
        end
        drive(1, RUN, 0, 0);
        @(negedge clk);
        drive(0, NOP, 0, 0);
        repeat (4) @(negedge clk);
        drive(1, STOP, 0, 0);
        @(negedge clk);
        drive(0, NOP, 0, 0);
        chk_val("sat_cnt4_hold", int'(cnt4), 15);
        chk_val("sat_done4", int'({done4, en4, busy4, halted4, err4}), 5'b10000);
        chk("sat_wide", 0, 0, 1, 0, 20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
